// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and NZCV flag indices.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_LSL   = 4'b0011;
    localparam logic [3:0] ALU_LSR   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_MUL   = 4'b1000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    // Packs individual flags into the NZCV bundle layout used by the flag register.
    function automatic logic [3:0] pack_nzcv(input logic n_f, input logic z_f,
                                             input logic c_f, input logic v_f);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n_f;
        f[FLAG_Z] = z_f;
        f[FLAG_C] = c_f;
        f[FLAG_V] = v_f;
        return f;
    endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, n cycles per product.
// done_o is asserted during the final step; product_o then holds the finished low n bits.
module seq_alu_mul #(
    parameter int n = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [n-1:0] a_i,
    input  logic [n-1:0] b_i,
    output logic         done_o,
    output logic [n-1:0] product_o
);
    localparam int CW = $clog2(n);

    logic [n-1:0]  acc_q;
    logic [n-1:0]  mcand_q;
    logic [n-1:0]  mplier_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic [n-1:0]  acc_d;

    // Next accumulator value for the step taken at the coming edge.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // Operand latch on start, then one shift-add step per cycle while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
            busy_q   <= (cnt_q != CW'(n - 1));
        end else begin
            busy_q   <= 1'b0;
        end
    end

    assign done_o    = busy_q && (cnt_q == CW'(n - 1));
    assign product_o = acc_d;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with NZCV flags and valid/ready handshakes on request and result.
// Single-cycle ops complete in one cycle; MUL is delegated to the iterative multiplier.
module seq_alu
    import alu_pkg::*;
#(
    parameter int n  = 64,
    parameter int SW = $clog2(n)
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          InValid,
    output logic          InReady,
    input  logic [n-1:0]  BusA,
    input  logic [n-1:0]  BusB,
    input  logic [SW-1:0] ShAmt,
    input  logic [3:0]    ALUCtrl,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [n-1:0]  BusW,
    output logic          Zero,
    output logic          Negative,
    output logic          Carry,
    output logic          Overflow
);
    state_t       state_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic [n-1:0] bus_w_q;
    logic [3:0]   flags_q;

    logic         accept_s;
    logic         mul_start_s;
    logic         mul_done_s;
    logic [n-1:0] mul_prod_s;
    logic [n:0]   ext_s;
    logic [n-1:0] res_d;
    logic         carry_d;
    logic         ovf_d;

    assign accept_s    = InValid && in_ready_q;
    assign mul_start_s = accept_s && (ALUCtrl == ALU_MUL);

    seq_alu_mul #(.n(n)) u_mul (
        .clk       (CLK),
        .rst       (Reset),
        .start_i   (mul_start_s),
        .a_i       (BusA),
        .b_i       (BusB),
        .done_o    (mul_done_s),
        .product_o (mul_prod_s)
    );

    // Single-cycle result and C/V; the extra top (or bottom) bit of ext_s carries out.
    always_comb begin
        ext_s   = '0;
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (ALUCtrl)
            ALU_AND:   res_d = BusA & BusB;
            ALU_OR:    res_d = BusA | BusB;
            ALU_PASSB: res_d = BusB;
            ALU_ADD: begin
                ext_s   = {1'b0, BusA} + {1'b0, BusB};
                res_d   = ext_s[n-1:0];
                carry_d = ext_s[n];
                ovf_d   = (BusA[n-1] == BusB[n-1]) && (ext_s[n-1] != BusA[n-1]);
            end
            ALU_SUB: begin
                // A + ~B + 1: carry out is the ARM no-borrow flag.
                ext_s   = {1'b0, BusA} + {1'b0, ~BusB} + {{n{1'b0}}, 1'b1};
                res_d   = ext_s[n-1:0];
                carry_d = ext_s[n];
                ovf_d   = (BusA[n-1] != BusB[n-1]) && (ext_s[n-1] != BusA[n-1]);
            end
            ALU_LSL: begin
                ext_s   = {1'b0, BusA} << ShAmt;
                res_d   = ext_s[n-1:0];
                carry_d = ext_s[n];
            end
            ALU_LSR: begin
                ext_s   = {BusA, 1'b0} >> ShAmt;
                res_d   = ext_s[n:1];
                carry_d = ext_s[0];
            end
            default: res_d = '0;
        endcase
    end

    // Control FSM with registered handshake, result and flag outputs.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bus_w_q     <= '0;
            flags_q     <= pack_nzcv(1'b0, 1'b1, 1'b0, 1'b0);
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        in_ready_q <= 1'b0;
                        if (ALUCtrl == ALU_MUL) begin
                            state_q <= MUL_RUN;
                        end else begin
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                            bus_w_q     <= res_d;
                            flags_q     <= pack_nzcv(res_d[n-1], (res_d == '0), carry_d, ovf_d);
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                MUL_RUN: begin
                    if (mul_done_s) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                        bus_w_q     <= mul_prod_s;
                        flags_q     <= pack_nzcv(mul_prod_s[n-1], (mul_prod_s == '0), 1'b0, 1'b0);
                    end else begin
                        state_q <= MUL_RUN;
                    end
                end
                HOLD: begin
                    if (OutReady) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign InReady  = in_ready_q;
    assign OutValid = out_valid_q;
    assign BusW     = bus_w_q;
    assign Negative = flags_q[FLAG_N];
    assign Zero     = flags_q[FLAG_Z];
    assign Carry    = flags_q[FLAG_C];
    assign Overflow = flags_q[FLAG_V];

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, handshake corner cases,
// and random operations compared against a plain-arithmetic reference model.
module tb_seq_alu;
    localparam int N  = 64;
    localparam int SW = 6;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          InValid;
    logic          InReady;
    logic [N-1:0]  BusA;
    logic [N-1:0]  BusB;
    logic [SW-1:0] ShAmt;
    logic [3:0]    ALUCtrl;
    logic          OutValid;
    logic          OutReady;
    logic [N-1:0]  BusW;
    logic          Zero;
    logic          Negative;
    logic          Carry;
    logic          Overflow;

    int total = 0;
    int bad   = 0;

    seq_alu #(.n(N), .SW(SW)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .BusA     (BusA),
        .BusB     (BusB),
        .ShAmt    (ShAmt),
        .ALUCtrl  (ALUCtrl),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .BusW     (BusW),
        .Zero     (Zero),
        .Negative (Negative),
        .Carry    (Carry),
        .Overflow (Overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]    op;
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [SW-1:0] sh;
        logic [N-1:0]  w;
        logic [3:0]    nzcv;
        int            lat;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model from the arithmetic definitions; returns {W, N, Z, C, V}.
    function automatic logic [67:0] model(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input logic [5:0] sh);
        logic [63:0] w;
        logic c;
        logic v;
        w = 64'd0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'h0: w = a & b;
            4'h1: w = a | b;
            4'h2: begin
                w = a + b;
                c = (w < a);
                v = (a[63] == b[63]) && (w[63] != a[63]);
            end
            4'h6: begin
                w = a - b;
                c = (a >= b);
                v = (a[63] != b[63]) && (w[63] != a[63]);
            end
            4'h3: begin
                w = a << sh;
                c = (sh == 6'd0) ? 1'b0 : a[64 - int'(sh)];
            end
            4'h4: begin
                w = a >> sh;
                c = (sh == 6'd0) ? 1'b0 : a[int'(sh) - 1];
            end
            4'h7: w = b;
            4'h8: w = a * b;
            default: w = 64'd0;
        endcase
        return {w, w[63], (w == 64'd0), c, v};
    endfunction

    // Issue one request, wait (bounded) for the result, then complete the handshake.
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] sh, output logic [63:0] w,
                          output logic [3:0] f, output int lat);
        @(negedge CLK);
        ALUCtrl = op;
        BusA    = a;
        BusB    = b;
        ShAmt   = sh;
        InValid = 1'b1;
        @(negedge CLK);
        InValid = 1'b0;
        lat     = 1;
        while (!OutValid && lat < 200) begin
            @(negedge CLK);
            lat++;
        end
        w        = BusW;
        f        = {Negative, Zero, Carry, Overflow};
        OutReady = 1'b1;
        @(negedge CLK);
        OutReady = 1'b0;
        chk("drop_valid", {63'd0, OutValid}, 64'd0);
        chk("ready_back", {63'd0, InReady}, 64'd1);
    endtask

    logic [3:0]  ops [11];
    logic [63:0] rw;
    logic [3:0]  rf;
    int          rlat;
    logic [67:0] exp_r;
    int          cnt;

    initial begin
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h5, 4'h9, 4'hF};

        tbl[0]  = '{4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 64'd0, 4'b0110, 1};
        tbl[1]  = '{4'h6, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0,
                    64'h8000_0000_0000_0000, 4'b1001, 1};
        tbl[2]  = '{4'h6, 64'd5, 64'd5, 6'd0, 64'd0, 4'b0110, 1};
        tbl[3]  = '{4'h3, 64'h8000_0000_0000_0001, 64'd0, 6'd1, 64'd2, 4'b0010, 1};
        tbl[4]  = '{4'h4, 64'h10, 64'd0, 6'd4, 64'd1, 4'b0000, 1};
        tbl[5]  = '{4'h3, 64'h1234, 64'd0, 6'd0, 64'h1234, 4'b0000, 1};
        tbl[6]  = '{4'h0, 64'hF0F0, 64'hFF00, 6'd0, 64'hF000, 4'b0000, 1};
        tbl[7]  = '{4'h1, 64'h0F, 64'hF0, 6'd0, 64'hFF, 4'b0000, 1};
        tbl[8]  = '{4'h7, 64'd3, 64'h8000_0000_0000_0000, 6'd0, 64'h8000_0000_0000_0000, 4'b1000, 1};
        tbl[9]  = '{4'h5, 64'd1, 64'd1, 6'd3, 64'd0, 4'b0100, 1};
        tbl[10] = '{4'h2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 64'h8000_0000_0000_0000, 4'b1001, 1};
        tbl[11] = '{4'h4, 64'h3, 64'd0, 6'd1, 64'd1, 4'b0010, 1};
        tbl[12] = '{4'h8, 64'd12345, 64'd678, 6'd0, 64'd8369910, 4'b0000, 65};
        tbl[13] = '{4'h8, 64'hDEAD_BEEF, 64'd0, 6'd0, 64'd0, 4'b0100, 65};

        Reset    = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b0;
        BusA     = '0;
        BusB     = '0;
        ShAmt    = '0;
        ALUCtrl  = 4'h0;
        #1;
        chk("rst_inready", {63'd0, InReady}, 64'd1);
        chk("rst_outvalid", {63'd0, OutValid}, 64'd0);
        chk("rst_busw", BusW, 64'd0);
        chk("rst_nzcv", {60'd0, Negative, Zero, Carry, Overflow}, 64'b0100);
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;

        // OutReady while nothing is pending must not disturb anything.
        OutReady = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        OutReady = 1'b0;
        chk("idle_outready", {62'd0, OutValid, InReady}, 64'b01);

        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, rw, rf, rlat);
            chk($sformatf("vec%0d_w", i), rw, tbl[i].w);
            chk($sformatf("vec%0d_nzcv", i), {60'd0, rf}, {60'd0, tbl[i].nzcv});
            chk($sformatf("vec%0d_lat", i), 64'(rlat), 64'(tbl[i].lat));
        end

        // ADD with OutReady held high: OutValid lasts exactly one cycle.
        @(negedge CLK);
        ALUCtrl  = 4'h2;
        BusA     = 64'hFFFF_FFFF_FFFF_FFFF;
        BusB     = 64'd1;
        InValid  = 1'b1;
        OutReady = 1'b1;
        @(negedge CLK);
        InValid = 1'b0;
        chk("add1_valid", {63'd0, OutValid}, 64'd1);
        chk("add1_w", BusW, 64'd0);
        chk("add1_nzcv", {60'd0, Negative, Zero, Carry, Overflow}, 64'b0110);
        @(negedge CLK);
        chk("add1_pulse", {63'd0, OutValid}, 64'd0);
        OutReady = 1'b0;

        // Backpressure: result and flags hold until OutReady.
        @(negedge CLK);
        ALUCtrl = 4'h2;
        BusA    = 64'd3;
        BusB    = 64'd4;
        InValid = 1'b1;
        @(negedge CLK);
        InValid = 1'b0;
        cnt     = 0;
        for (int k = 0; k < 5; k++) begin
            if (OutValid !== 1'b1 || BusW !== 64'd7 ||
                {Negative, Zero, Carry, Overflow} !== 4'b0000 || InReady !== 1'b0) cnt++;
            @(negedge CLK);
        end
        chk("bp_stable", 64'(cnt), 64'd0);
        OutReady = 1'b1;
        @(negedge CLK);
        OutReady = 1'b0;
        chk("bp_release", {62'd0, OutValid, InReady}, 64'b01);

        // MUL with a competing request held during the busy window.
        @(negedge CLK);
        ALUCtrl = 4'h8;
        BusA    = 64'd7;
        BusB    = 64'd9;
        InValid = 1'b1;
        @(negedge CLK);
        InValid = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge CLK);
        ALUCtrl = 4'h2;
        BusA    = 64'd1;
        BusB    = 64'd1;
        InValid = 1'b1;
        cnt     = 0;
        rlat    = 0;
        while (!OutValid && rlat < 200) begin
            if (InReady) cnt++;
            @(negedge CLK);
            rlat++;
        end
        InValid = 1'b0;
        chk("busy_inready", 64'(cnt), 64'd0);
        chk("busy_mul_w", BusW, 64'd63);
        OutReady = 1'b1;
        @(negedge CLK);
        OutReady = 1'b0;
        cnt      = 0;
        for (int k = 0; k < 5; k++) begin
            if (OutValid) cnt++;
            @(negedge CLK);
        end
        chk("busy_not_queued", 64'(cnt), 64'd0);

        // Random operations against the reference model.
        for (int i = 0; i < 50; i++) begin
            logic [3:0]  op;
            logic [63:0] a;
            logic [63:0] b;
            logic [5:0]  sh;
            op = ops[$urandom_range(0, 10)];
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            sh = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 15));
            exp_r = model(op, a, b, sh);
            run_op(op, a, b, sh, rw, rf, rlat);
            chk($sformatf("rnd%0d_w", i), rw, exp_r[67:4]);
            chk($sformatf("rnd%0d_nzcv", i), {60'd0, rf}, {60'd0, exp_r[3:0]});
            chk($sformatf("rnd%0d_lat", i), 64'(rlat), (op == 4'h8) ? 64'd65 : 64'd1);
        end

        // Reset asserted mid-multiply aborts it with no output.
        @(negedge CLK);
        ALUCtrl = 4'h8;
        BusA    = 64'd12345;
        BusB    = 64'd678;
        InValid = 1'b1;
        @(negedge CLK);
        InValid = 1'b0;
        for (int k = 0; k < 9; k++) @(negedge CLK);
        #2;
        Reset = 1'b1;
        #1;
        chk("mrst_inready", {63'd0, InReady}, 64'd1);
        chk("mrst_outvalid", {63'd0, OutValid}, 64'd0);
        chk("mrst_busw", BusW, 64'd0);
        chk("mrst_nzcv", {60'd0, Negative, Zero, Carry, Overflow}, 64'b0100);
        @(negedge CLK);
        Reset = 1'b0;
        cnt   = 0;
        for (int k = 0; k < 80; k++) begin
            if (OutValid || !InReady) cnt++;
            @(negedge CLK);
        end
        chk("mrst_after", 64'(cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
